lfsr_rx_checker: RTL
====================

Name: lfsr_rx_checker

Overview:
Receive-side pattern checker for UART loopback tests. Consumes bytes from the UART receiver and predicts each next byte using the same 8-bit LFSR that generates the transmit pattern. Self-synchronises to the incoming stream and counts matches and mismatches. Sits directly downstream of the UART RX path, mirroring the LFSR pattern source on the TX side.

Parameters:
CNT_WIDTH, 16, width of the match and error counters; both saturate at all-ones.
LOCK_MATCHES, 4, consecutive matches in VERIFY needed to enter LOCKED (range 1-15).
LOSS_ERRORS, 3, consecutive mismatches in LOCKED that force a return to HUNT (range 1-15).

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
rx_data  input  8  received byte; sampled only when rx_valid=1.
clear  input  1  synchronous clear of the counters; state and lock are unaffected.
locked  output  1  high while in LOCKED.
err_pulse  output  1  one-cycle pulse, registered, on each mismatch in LOCKED.
match_count  output  CNT_WIDTH  matches counted in LOCKED.
error_count  output  CNT_WIDTH  mismatches counted in LOCKED.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- LFSR step: next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. The generator seed is 0xFF, and 0x00 never occurs.
- Internal registers: state (HUNT, VERIFY, LOCKED), expected[7:0], a run counter of 4 bits.
- Reset: state=HUNT, expected=0xFF, run=0, locked=0, err_pulse=0, match_count=0, error_count=0.
- All transitions occur only on cycles with rx_valid=1. With rx_valid=0, every register holds its value and err_pulse=0.
- HUNT:
  - rx_data != 0x00: expected <= next(rx_data), run <= 0, go to VERIFY.
  - rx_data == 0x00: stay in HUNT. A zero byte is an invalid seed.
- VERIFY:
  - rx_data == expected: run+1. When run+1 == LOCK_MATCHES, go to LOCKED and clear run.
  - Mismatch: re-seed exactly as in HUNT. A zero byte returns to HUNT.
  - In both cases expected <= next(rx_data).
- LOCKED:
  - expected <= next(expected) always. Expected never re-seeds from received data, so a corrupted byte does not break alignment.
  - Match: match_count+1, run <= 0.
  - Mismatch: error_count+1, err_pulse=1 on the following cycle, run+1.
  - When run+1 == LOSS_ERRORS: go to HUNT and clear run. The mismatch that triggers the loss is still counted.
- locked is registered from state. It rises on the cycle after the LOCK_MATCHES-th match is accepted and falls on the cycle after the LOSS_ERRORS-th consecutive mismatch.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clear=1: both counters go to 0 (and the bit-error counter when the optional feature is compiled in). clear takes priority, so an event on the same cycle is not counted. err_pulse still fires on a simultaneous mismatch.
- Reset mid-stream: all state returns to reset values, and the checker re-hunts from the next valid byte.
- Latency: one rx_valid byte in, registered outputs valid on the next clk edge.

Optional Feature:
Macro LFSR_CHK_BITERR_EN.
- Defined: adds output bit_error_count [CNT_WIDTH-1:0], which accumulates popcount(rx_data ^ expected) on each mismatch in LOCKED. It saturates, is cleared by rst and clear, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Lock: after reset, send 0xFF,0xFE,0xFC,0xF8,0xF0. Required: VERIFY after 0xFF; locked=1 one cycle after 0xF0; match_count=0, error_count=0.
2. Tracking: continue with 0xE1,0xC2,0x85. Required: match_count=3, err_pulse never asserted, locked stays 1.
3. Single error: from lock with expected 0xC2, send 0xC3 then 0x85. Required: err_pulse high one cycle, error_count=1, bit_error_count=1 (with macro), locked=1, match_count increments on 0x85.
4. Loss of lock: in LOCKED, send three bytes that all mismatch, e.g. 0x00,0x00,0x00. Required: error_count=3, locked falls after the third byte, state HUNT. A following 0x00 keeps HUNT; a following 0xFF enters VERIFY.
5. Clear and saturation: CNT_WIDTH=4, inject 20 spaced errors (keeping lock via matches between them). Required: error_count holds at 15. Then clear=1 with a simultaneous mismatch: error_count=0 the next cycle, err_pulse=1.
6. Reset mid-operation: assert rst while LOCKED with counters non-zero. Required: next cycle locked=0, counters=0. The checker then relocks with scenario 1 stimulus.

Source files
------------

// File: rtl/lfsr_rx_checker.sv
// Receive-side LFSR pattern checker: self-synchronises to the incoming byte stream,
// tracks lock and counts matches/mismatches. Optional bit-error counter: LFSR_CHK_BITERR_EN.
module lfsr_rx_checker #(
   parameter int CNT_WIDTH    = 16,
   parameter int LOCK_MATCHES = 4,
   parameter int LOSS_ERRORS  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic                 clear,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] match_count,
   output logic [CNT_WIDTH-1:0] error_count
`ifdef LFSR_CHK_BITERR_EN
   ,
   output logic [CNT_WIDTH-1:0] bit_error_count
`endif
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
   localparam logic [3:0] LOSS_N = 4'(LOSS_ERRORS);

   state_t     state, state_nx;
   logic [7:0] expected, expected_nx;
   logic [3:0] run, run_nx, run_inc;
   logic       hit_match, hit_err;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

`ifdef LFSR_CHK_BITERR_EN
   function automatic logic [3:0] popcount8(input logic [7:0] x);
      logic [3:0] p;
      p = 4'd0;
      for (int i = 0; i < 8; i++) p = p + 4'(x[i]);
      return p;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                    input logic [3:0]           n);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, c} + (CNT_WIDTH + 1)'(n);
      return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction
`endif

   assign run_inc = run + 4'd1;

   always_comb begin
      state_nx    = state;
      expected_nx = expected;
      run_nx      = run;
      hit_match   = 1'b0;
      hit_err     = 1'b0;
      if (rx_valid) begin
         case (state)
            HUNT: begin
               if (rx_data != 8'h00) begin
                  expected_nx = lfsr_next(rx_data);
                  run_nx      = 4'd0;
                  state_nx    = VERIFY;
               end
            end
            VERIFY: begin
               expected_nx = lfsr_next(rx_data);
               if (rx_data == expected) begin
                  if (run_inc == LOCK_N) begin
                     state_nx = LOCKED;
                     run_nx   = 4'd0;
                  end else begin
                     run_nx = run_inc;
                  end
               end else begin
                  // A mismatch re-seeds from the received byte; zero cannot seed.
                  run_nx   = 4'd0;
                  state_nx = (rx_data == 8'h00) ? HUNT : VERIFY;
               end
            end
            LOCKED: begin
               // Free-running prediction keeps alignment through corrupted bytes.
               expected_nx = lfsr_next(expected);
               if (rx_data == expected) begin
                  hit_match = 1'b1;
                  run_nx    = 4'd0;
               end else begin
                  hit_err = 1'b1;
                  if (run_inc == LOSS_N) begin
                     state_nx = HUNT;
                     run_nx   = 4'd0;
                  end else begin
                     run_nx = run_inc;
                  end
               end
            end
            default: begin
               state_nx = HUNT;
               run_nx   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         expected    <= 8'hFF;
         run         <= 4'd0;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         match_count <= '0;
         error_count <= '0;
      end else begin
         state     <= state_nx;
         expected  <= expected_nx;
         run       <= run_nx;
         locked    <= (state_nx == LOCKED);
         err_pulse <= hit_err;
         // clear wins over a same-cycle event; err_pulse is unaffected.
         if (clear) begin
            match_count <= '0;
            error_count <= '0;
         end else begin
            if (hit_match) match_count <= sat_inc(match_count);
            if (hit_err)   error_count <= sat_inc(error_count);
         end
      end
   end

`ifdef LFSR_CHK_BITERR_EN
   always_ff @(posedge clk) begin
      if (rst || clear) bit_error_count <= '0;
      else if (hit_err) bit_error_count <= sat_add(bit_error_count, popcount8(rx_data ^ expected));
   end
`endif

endmodule
